// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: prefix byte values and the state encodings of the
// scancode decoder and the typematic repeat engine.
package ps2_defs;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DELAY = 2'd1,
    R_RATE  = 2'd2
  } rep_state_t;

endpackage

// File: rtl/ps2_scan_decoder.sv
// PS/2 scancode prefix decoder. Folds E0 (extended) and F0 (break) prefixes
// into a single make/break event carrying a 9-bit {extended, scancode} code.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   ps2_out/ps2_pulse  received byte and its one-cycle strobe
//   evt_valid          registered one-cycle event strobe
//   evt_make           1 = make, 0 = break
//   evt_code           {extended, scancode}
module ps2_scan_decoder
  import ps2_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_out,
  input  logic       ps2_pulse,
  output logic       evt_valid,
  output logic       evt_make,
  output logic [8:0] evt_code
);

  dec_state_t state_q, state_d;
  logic       vld_d, make_d;
  logic [8:0] code_d;

  always_comb begin
    state_d = state_q;
    vld_d   = 1'b0;
    make_d  = 1'b0;
    code_d  = {1'b0, ps2_out};
    if (ps2_pulse) begin
      case (state_q)
        DEC_IDLE: begin
          if (ps2_out == PS2_EXT)        state_d = DEC_EXT;
          else if (ps2_out == PS2_BREAK) state_d = DEC_BRK;
          else begin
            vld_d  = 1'b1;
            make_d = 1'b1;
          end
        end
        DEC_EXT: begin
          if (ps2_out == PS2_BREAK) state_d = DEC_EXT_BRK;
          else begin
            vld_d   = 1'b1;
            make_d  = 1'b1;
            code_d  = {1'b1, ps2_out};
            state_d = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          vld_d   = 1'b1;
          state_d = DEC_IDLE;
        end
        DEC_EXT_BRK: begin
          vld_d   = 1'b1;
          code_d  = {1'b1, ps2_out};
          state_d = DEC_IDLE;
        end
        default: state_d = DEC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DEC_IDLE;
      evt_valid <= 1'b0;
      evt_make  <= 1'b0;
      evt_code  <= '0;
    end else begin
      state_q   <= state_d;
      evt_valid <= vld_d;
      evt_make  <= make_d;
      evt_code  <= code_d;
    end
  end

endmodule

// File: rtl/ps2_key_scheduler.sv
// Central PS/2 key-event controller. Matches decoded make/break events against
// a programmable key table, tracks held keys, emits one press pulse per slot
// and auto-repeats the most recently pressed, still-held key.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ps2_out, ps2_pulse  scancode byte stream from the PS/2 receiver
//   cfg_we/idx/code     table write port ({extended, scancode})
//   pulse               one-cycle press/repeat pulse per slot (at most one bit)
//   held                slot currently held down
//   active_valid/idx    repeat engine armed / slot it targets
module ps2_key_scheduler
  import ps2_defs::*;
#(
  parameter int NKEYS         = 8,
  parameter int IDXW          = 3,
  parameter int CNT_W         = 22,
  parameter int REPEAT_DELAY  = 4194303,
  parameter int REPEAT_PERIOD = 1048575
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      ps2_out,
  input  logic            ps2_pulse,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [8:0]      cfg_code,
  output logic [NKEYS-1:0] pulse,
  output logic [NKEYS-1:0] held,
  output logic            active_valid,
  output logic [IDXW-1:0] active_idx
);

  localparam logic [CNT_W-1:0] DLY_RLD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_RLD = CNT_W'(REPEAT_PERIOD - 1);

  logic       evt_valid, evt_make;
  logic [8:0] evt_code;

  ps2_scan_decoder u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_out   (ps2_out),
    .ps2_pulse (ps2_pulse),
    .evt_valid (evt_valid),
    .evt_make  (evt_make),
    .evt_code  (evt_code)
  );

  logic [NKEYS-1:0][8:0] tbl_q;
  logic [NKEYS-1:0]      hit, cfg_sel, act_oh, m_oh;
  logic [NKEYS-1:0]      held_q, held_d, pulse_q, pulse_d;
  logic                  act_valid_q, act_valid_d;
  logic [IDXW-1:0]       act_idx_q, act_idx_d, m_idx;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  rep_state_t            rstate_q, rstate_d;
  logic                  m_hit, evt_ok, m_held, fire;

  // Per-slot compare; an all-zero entry is an empty slot and never matches.
  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_slot
    assign hit[gi]     = (tbl_q[gi] == evt_code) && (tbl_q[gi] != 9'h000);
    assign cfg_sel[gi] = cfg_we && (cfg_idx == IDXW'(gi));
    assign act_oh[gi]  = (act_idx_q == IDXW'(gi));
  end

  // Lowest matching index wins.
  assign m_oh  = hit & (~hit + NKEYS'(1));
  assign m_hit = |hit;
  always_comb begin
    m_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--)
      if (hit[i]) m_idx = IDXW'(i);
  end

  // A table write on the matched slot in the same cycle drops the event.
  assign evt_ok = evt_valid && m_hit && !(|(m_oh & cfg_sel));
  assign m_held = |(m_oh & held_q);

  always_comb begin
    held_d      = held_q;
    pulse_d     = '0;
    act_valid_d = act_valid_q;
    act_idx_d   = act_idx_q;
    cnt_d       = cnt_q;
    rstate_d    = rstate_q;
    fire        = 1'b0;

    // Typematic countdown; expiry reloads with the rate period.
    if (rstate_q != R_IDLE) begin
      if (cnt_q == '0) begin
        fire     = 1'b1;
        cnt_d    = PER_RLD;
        rstate_d = R_RATE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Reprogramming a slot releases it; if it was the repeat target, stop.
    held_d = held_d & ~cfg_sel;
    if (act_valid_q && |(cfg_sel & act_oh)) begin
      act_valid_d = 1'b0;
      rstate_d    = R_IDLE;
      fire        = 1'b0;
    end

    // Events override the engine: a new press retargets it, releasing the
    // target stops it, and either suppresses a coincident repeat pulse.
    if (evt_ok) begin
      if (evt_make && !m_held) begin
        held_d      = held_d | m_oh;
        pulse_d     = m_oh;
        act_idx_d   = m_idx;
        act_valid_d = 1'b1;
        cnt_d       = DLY_RLD;
        rstate_d    = R_DELAY;
        fire        = 1'b0;
      end else if (!evt_make && m_held) begin
        held_d = held_d & ~m_oh;
        if (act_valid_q && (m_idx == act_idx_q)) begin
          act_valid_d = 1'b0;
          rstate_d    = R_IDLE;
          fire        = 1'b0;
        end
      end
    end

    if (fire) pulse_d = act_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q      <= '0;
      pulse_q     <= '0;
      act_valid_q <= 1'b0;
      act_idx_q   <= '0;
      cnt_q       <= '0;
      rstate_q    <= R_IDLE;
    end else begin
      held_q      <= held_d;
      pulse_q     <= pulse_d;
      act_valid_q <= act_valid_d;
      act_idx_q   <= act_idx_d;
      cnt_q       <= cnt_d;
      rstate_q    <= rstate_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++)
        if (cfg_sel[i]) tbl_q[i] <= cfg_code;
    end
  end

  assign pulse        = pulse_q;
  assign held         = held_q;
  assign active_valid = act_valid_q;
  assign active_idx   = act_idx_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
module tb_ps2_key_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ps2_out;
  logic       ps2_pulse;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [8:0] cfg_code;
  logic [7:0] pulse, held;
  logic       active_valid;
  logic [2:0] active_idx;

  ps2_key_scheduler #(
    .NKEYS(8), .IDXW(3), .CNT_W(22), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_out(ps2_out), .ps2_pulse(ps2_pulse),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .pulse(pulse), .held(held), .active_valid(active_valid), .active_idx(active_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [7:0] v; } pexp_t;
  typedef struct {
    string nm; int c; logic [7:0] h; logic av; logic [2:0] ai; logic [7:0] p; bit fin;
  } sexp_t;

  pexp_t pq[$];
  sexp_t sq[$];
  int n_chk = 0;
  int n_fail = 0;

  // Monitor: pops an expected pulse whenever the DUT pulses, and checks
  // posted state snapshots at their cycle.
  pexp_t pe;
  sexp_t se;
  always @(negedge clk) begin
    if (pulse !== 8'h00) begin
      n_chk++;
      if (pq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d got=%h expected none", cyc, pulse);
      end else begin
        pe = pq.pop_front();
        if (pe.c != cyc || pe.v !== pulse) begin
          n_fail++;
          $display("FAIL pulse cyc=%0d got=%h expected cyc=%0d val=%h", cyc, pulse, pe.c, pe.v);
        end
      end
    end
    while (sq.size() > 0 && sq[0].c <= cyc) begin
      se = sq.pop_front();
      n_chk++;
      if (se.c != cyc) begin
        n_fail++;
        $display("FAIL %s missed check cyc=%0d", se.nm, se.c);
      end else if ({held, active_valid, active_idx, pulse} !== {se.h, se.av, se.ai, se.p}) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got held=%h av=%b ai=%0d pulse=%h expected held=%h av=%b ai=%0d pulse=%h",
                 se.nm, cyc, held, active_valid, active_idx, pulse, se.h, se.av, se.ai, se.p);
      end
      if (se.fin) begin
        n_chk++;
        if (pq.size() != 0) begin
          n_fail++;
          $display("FAIL missing_pulses got %0d outstanding expected 0 (next cyc=%0d)", pq.size(), pq[0].c);
        end
      end
    end
  end

  task automatic push_p(input int c, input logic [7:0] v);
    pexp_t e;
    e.c = c; e.v = v;
    pq.push_back(e);
  endtask

  task automatic push_s(input string nm, input int c, input logic [7:0] h, input logic av,
                        input logic [2:0] ai, input bit fin);
    sexp_t e;
    e.nm = nm; e.c = c; e.h = h; e.av = av; e.ai = ai; e.p = 8'h00; e.fin = fin;
    sq.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe for one cycle starting at cycle c; a make lands on pulse at c+2.
  task automatic send_at(input int c, input logic [7:0] b);
    wait_cyc(c);
    ps2_out = b; ps2_pulse = 1'b1;
    @(posedge clk); #1;
    ps2_pulse = 1'b0;
  endtask

  task automatic cfg_at(input int c, input logic [2:0] idx, input logic [8:0] code);
    wait_cyc(c);
    cfg_we = 1'b1; cfg_idx = idx; cfg_code = code;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    int b;
    ps2_out = 8'h00; ps2_pulse = 1'b0; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_code = 9'h000;
    rst_n = 1'b0;
    push_s("reset", 2, 8'h00, 1'b0, 3'd0, 1'b0);
    wait_cyc(4);
    rst_n = 1'b1;
    cfg_at(6, 3'd2, 9'h01C);

    // Press and hold slot2, repeats at +20,+28,...; release before +60.
    b = 10;
    push_p(b + 2, 8'h04);
    for (int k = 0; k < 5; k++) push_p(b + 22 + 8 * k, 8'h04);
    push_s("press_slot2", b + 4, 8'h04, 1'b1, 3'd2, 1'b0);
    push_s("release_slot2", b + 64, 8'h00, 1'b0, 3'd2, 1'b0);
    send_at(b, 8'h1C);
    send_at(b + 58, 8'hF0);
    send_at(b + 59, 8'h1C);

    // Release lands on the same edge as the second repeat: no pulse.
    b = 90;
    push_p(b + 2, 8'h04);
    push_p(b + 22, 8'h04);
    push_s("break_vs_expiry", b + 33, 8'h00, 1'b0, 3'd2, 1'b0);
    send_at(b, 8'h1C);
    send_at(b + 27, 8'hF0);
    send_at(b + 28, 8'h1C);

    // Extended vs plain codes.
    cfg_at(130, 3'd0, 9'h174);
    cfg_at(132, 3'd1, 9'h074);
    b = 140;
    push_p(b + 3, 8'h01);
    push_p(b + 4, 8'h02);
    push_s("ext_break", b + 8, 8'h02, 1'b1, 3'd1, 1'b0);
    push_s("plain_break", b + 14, 8'h00, 1'b0, 3'd1, 1'b0);
    send_at(b, 8'hE0);
    send_at(b + 1, 8'h74);
    send_at(b + 2, 8'h74);
    send_at(b + 3, 8'hE0);
    send_at(b + 4, 8'hF0);
    send_at(b + 5, 8'h74);
    send_at(b + 9, 8'hF0);
    send_at(b + 10, 8'h74);

    // Retarget to slot5; releasing slot2 leaves slot5 repeating.
    cfg_at(170, 3'd5, 9'h015);
    b = 180;
    push_p(b + 2, 8'h04);
    push_p(b + 7, 8'h20);
    push_p(b + 27, 8'h20);
    push_p(b + 35, 8'h20);
    push_p(b + 43, 8'h20);
    push_s("retarget", b + 15, 8'h20, 1'b1, 3'd5, 1'b0);
    push_s("release_slot5", b + 50, 8'h00, 1'b0, 3'd5, 1'b0);
    send_at(b, 8'h1C);
    send_at(b + 5, 8'h15);
    send_at(b + 10, 8'hF0);
    send_at(b + 11, 8'h1C);
    send_at(b + 45, 8'hF0);
    send_at(b + 46, 8'h15);

    // Duplicate codes, typematic resend, cfg write releasing a held slot.
    cfg_at(240, 3'd2, 9'h000);
    cfg_at(242, 3'd3, 9'h01C);
    cfg_at(244, 3'd6, 9'h01C);
    b = 250;
    push_p(b + 2, 8'h08);
    push_p(b + 17, 8'h08);
    push_s("dup_resend", b + 6, 8'h08, 1'b1, 3'd3, 1'b0);
    push_s("dup_release", b + 12, 8'h00, 1'b0, 3'd3, 1'b0);
    push_s("cfg_clears_held", b + 22, 8'h00, 1'b0, 3'd3, 1'b0);
    send_at(b, 8'h1C);
    send_at(b + 3, 8'h1C);
    send_at(b + 7, 8'hF0);
    send_at(b + 8, 8'h1C);
    send_at(b + 15, 8'h1C);
    cfg_at(b + 19, 3'd3, 9'h01C);

    // Reset after an F0 prefix while a key is held.
    b = 300;
    push_p(b - 2, 8'h08);
    push_p(b + 12, 8'h04);
    push_s("mid_reset", b + 3, 8'h00, 1'b0, 3'd0, 1'b0);
    push_s("post_reset_make", b + 13, 8'h04, 1'b1, 3'd2, 1'b0);
    push_s("post_reset_break", b + 19, 8'h00, 1'b0, 3'd2, 1'b0);
    push_s("final", 360, 8'h00, 1'b0, 3'd2, 1'b1);
    send_at(b - 4, 8'h1C);
    send_at(b, 8'hF0);
    wait_cyc(b + 2);
    rst_n = 1'b0;
    wait_cyc(b + 5);
    rst_n = 1'b1;
    cfg_at(b + 7, 3'd2, 9'h01C);
    send_at(b + 10, 8'h1C);
    send_at(b + 14, 8'hF0);
    send_at(b + 15, 8'h1C);

    wait_cyc(362);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
